// File: rtl/sa_out_writeback.sv
// Purpose: buffer quantized systolic-array output rows and drain them to a shared SRAM write port.
// Latency: 2 cycles from row strobe to SRAM write strobe when the port is granted.
// Backpressure: rows queue while sram_gnt is low; a row arriving on a full FIFO with no pop is dropped and flagged.

// Generic FIFO used by the write-back stage. No overflow or underflow
// protection: the caller gates i_push and i_pop.
module sa_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdat,
  output logic [W-1:0]  o_rdat,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage is not reset; a reset empties the FIFO by clearing the pointers.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdat  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

module sa_out_writeback #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_wen_n,
  input  logic [AW-1:0]              in_waddr,
  input  logic [N*8-1:0]             in_data,
  input  logic                       in_last,
  output logic                       sram_req,
  input  logic                       sram_gnt,
  output logic                       sram_wen_n,
  output logic [AW-1:0]              sram_waddr,
  output logic [N*8-1:0]             sram_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       flush_done,
  output logic                       overflow
);

  localparam int DW = N * 8;
  localparam int EW = AW + DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO entry: address in the upper bits, row data below.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } row_t;

  row_t          w_wr_row;
  row_t          w_rd_row;
  logic [EW-1:0] w_rd_bits;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_flush_hit;

  logic          r_wen_n;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_overflow;
  logic          r_armed;

  assign w_wr_row.addr = in_waddr;
  assign w_wr_row.dat  = in_data;

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign w_full = (w_count == FULL_CNT);
  assign w_pop  = sram_req & sram_gnt;
  assign w_push = ~in_wen_n & (~w_full | w_pop);
  assign w_drop = ~in_wen_n & w_full & ~w_pop;

  sa_wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdat  (w_wr_row),
    .o_rdat  (w_rd_bits),
    .o_count (w_count)
  );

  assign w_rd_row = row_t'(w_rd_bits);

  // Output registers: one-cycle write strobe per pop, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen_n <= 1'b1;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_wen_n <= 1'b0;
      r_waddr <= w_rd_row.addr;
      r_wdata <= w_rd_row.dat;
    end else begin
      r_wen_n <= 1'b1;
    end
  end

  // Sticky drop flag, cleared by a new job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (start) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // The job is complete once armed, the FIFO is empty and the last strobe is gone.
  assign w_flush_hit = r_armed & (w_count == '0) & r_wen_n & ~start;

  // Armed flag: start has priority over in_last; cleared on the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (start) begin
      r_armed <= 1'b0;
    end else if (in_last) begin
      r_armed <= 1'b1;
    end else if (w_flush_hit) begin
      r_armed <= 1'b0;
    end
  end

  assign sram_req   = (w_count != '0);
  assign sram_wen_n = r_wen_n;
  assign sram_waddr = r_waddr;
  assign sram_wdata = r_wdata;
  assign count      = w_count;
  assign busy       = (w_count != '0) | ~r_wen_n;
  assign flush_done = w_flush_hit;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sa_out_writeback.sv
// Purpose: directed scoreboard bench for sa_out_writeback.
// Latency: expects SRAM strobe 2 cycles after a granted row strobe.
// Backpressure: exercises gnt stalls, overflow drops and full push+pop.
module tb_sa_out_writeback;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 13;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_wen_n;
  logic [AW-1:0]   in_waddr;
  logic [N*8-1:0]  in_data;
  logic            in_last;
  logic            sram_req;
  logic            sram_gnt;
  logic            sram_wen_n;
  logic [AW-1:0]   sram_waddr;
  logic [N*8-1:0]  sram_wdata;
  logic [CW-1:0]   count;
  logic            busy;
  logic            flush_done;
  logic            overflow;

  sa_out_writeback #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_wen_n   (in_wen_n),
    .in_waddr   (in_waddr),
    .in_data    (in_data),
    .in_last    (in_last),
    .sram_req   (sram_req),
    .sram_gnt   (sram_gnt),
    .sram_wen_n (sram_wen_n),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .count      (count),
    .busy       (busy),
    .flush_done (flush_done),
    .overflow   (overflow)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic [N*8-1:0] d;
    int             c;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  int   wr_cnt = 0;
  int   last_wen_cyc = -1;
  int   fl_cnt = 0;
  int   fl_cyc = -1;
  int   max_count = 0;
  bit   gnt_toggle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N*8-1:0] mkdata(input logic [AW-1:0] a);
    logic [N*8-1:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = 8'(a) + 8'(i);
    return d;
  endfunction

  // Monitor: every write strobe is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(count) > max_count) max_count = int'(count);
      if (flush_done) begin
        fl_cnt++;
        fl_cyc = cyc;
      end
      if (!sram_wen_n) begin
        exp_t e;
        wr_cnt++;
        last_wen_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", 64'(sram_waddr), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 64'(sram_waddr), 64'(e.a));
          chk("wr_data", sram_wdata, e.d);
          if (e.c >= 0) chk("wr_latency_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  // Grant toggler for the flush scenario.
  always @(posedge clk) begin
    if (gnt_toggle) begin
      #1 sram_gnt = ~sram_gnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_row(input logic [AW-1:0] a, input bit last, input bit accept, input bit lat);
    exp_t e;
    in_wen_n = 1'b0;
    in_waddr = a;
    in_data  = mkdata(a);
    in_last  = last;
    if (accept) begin
      e.a = a;
      e.d = mkdata(a);
      e.c = lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    tick(1);
    in_wen_n = 1'b1;
    in_last  = 1'b0;
  endtask

  int w0;
  int f0;
  int k;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_wen_n = 1'b1;
    in_waddr = '0;
    in_data  = '0;
    in_last  = 1'b0;
    sram_gnt = 1'b0;
    tick(3);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(sram_req), 64'd0);
    chk("rst_wen_n", 64'(sram_wen_n), 64'd1);
    chk("rst_waddr", 64'(sram_waddr), 64'd0);
    chk("rst_wdata", sram_wdata, 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Uncontended stream of 8 rows.
    sram_gnt  = 1'b1;
    max_count = 0;
    for (int i = 0; i < 8; i++) drive_row(AW'(i), 1'b0, 1'b1, 1'b1);
    tick(4);
    chk("stream_max_count", 64'(max_count), 64'd1);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);
    chk("stream_busy_idle", 64'(busy), 64'd0);

    // Backpressure fill to DEPTH.
    sram_gnt = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) drive_row(AW'(32 + i), 1'b0, 1'b1, 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_req", 64'(sram_req), 64'd1);
    chk("fill_busy", 64'(busy), 64'd1);
    tick(2);
    chk("fill_no_write", 64'(wr_cnt - w0), 64'd0);
    sram_gnt = 1'b1;
    tick(6);
    chk("fill_drained", 64'(wr_cnt - w0), 64'd4);
    chk("fill_sb_empty", 64'(sb.size()), 64'd0);
    chk("fill_overflow", 64'(overflow), 64'd0);

    // Overflow: fifth row dropped.
    sram_gnt = 1'b0;
    for (int i = 0; i < 4; i++) drive_row(AW'(i), 1'b0, 1'b1, 1'b0);
    drive_row(AW'(4), 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    w0 = wr_cnt;
    sram_gnt = 1'b1;
    tick(8);
    chk("ovf_writes", 64'(wr_cnt - w0), 64'd4);
    chk("ovf_sb_empty", 64'(sb.size()), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ovf_cleared_by_start", 64'(overflow), 64'd0);

    // Full FIFO with simultaneous push and pop.
    sram_gnt = 1'b0;
    for (int i = 0; i < 4; i++) drive_row(AW'(16 + i), 1'b0, 1'b1, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    sram_gnt = 1'b1;
    drive_row(AW'(9), 1'b0, 1'b1, 1'b0);
    chk("full_pp_count", 64'(count), 64'd4);
    chk("full_pp_overflow", 64'(overflow), 64'd0);
    tick(8);
    chk("full_pp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with toggling grant.
    f0 = fl_cnt;
    sram_gnt = 1'b1;
    gnt_toggle = 1'b1;
    drive_row(AW'(100), 1'b0, 1'b1, 1'b0);
    drive_row(AW'(101), 1'b0, 1'b1, 1'b0);
    drive_row(AW'(102), 1'b1, 1'b1, 1'b0);
    tick(14);
    gnt_toggle = 1'b0;
    tick(2);
    sram_gnt = 1'b0;
    chk("flush_pulses", 64'(fl_cnt - f0), 64'd1);
    chk("flush_cycle", 64'(fl_cyc), 64'(last_wen_cyc + 1));
    chk("flush_sb_empty", 64'(sb.size()), 64'd0);

    // in_last on an idle block.
    tick(2);
    f0 = fl_cnt;
    k  = cyc;
    in_last = 1'b1;
    tick(1);
    in_last = 1'b0;
    tick(3);
    chk("idle_flush_pulses", 64'(fl_cnt - f0), 64'd1);
    chk("idle_flush_cycle", 64'(fl_cyc), 64'(k + 1));

    // Reset mid-drain.
    sram_gnt = 1'b0;
    for (int i = 0; i < 3; i++) drive_row(AW'(200 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_req", 64'(sram_req), 64'd0);
    chk("mid_rst_wen_n", 64'(sram_wen_n), 64'd1);
    tick(1);
    rst_n = 1'b1;
    sram_gnt = 1'b1;
    tick(6);
    chk("post_rst_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/sa_out_writeback.md
Name: sa_out_writeback

Overview:
Write-back stage directly downstream of the configurable systolic array wrapper.
- Captures each quantized output row: N int8 lanes, address and active-low write strobe.
- Buffers rows in a small FIFO and drains them to a shared output SRAM write port through a req/gnt arbiter.
- Lets the array keep producing while the SRAM port is granted elsewhere, and reports when all results of a job have landed.

Parameters:
N, 8, number of int8 lanes per output row (SRAM word = N*8 bits)
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 13, write address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; clears sticky status and flush state
in_wen_n  in  1  active-low row-valid strobe from the array
in_waddr  in  AW  destination word address of the row
in_data  in  N*8  quantized row; lane i = bits [8i+7:8i]
in_last  in  1  pulse coincident with or after the final row of a job (array done_all)
sram_req  out  1  request for the SRAM write port
sram_gnt  in  1  grant from the arbiter; sampled only while sram_req=1
sram_wen_n  out  1  active-low SRAM write enable (registered)
sram_waddr  out  AW  SRAM write address (registered)
sram_wdata  out  N*8  SRAM write data (registered)
count  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  FIFO non-empty or SRAM write in flight
flush_done  out  1  one-cycle pulse: job fully written
overflow  out  1  sticky: a row was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous on rst_n and has immediate effect mid-operation: pointers and count = 0; sram_req=0; sram_wen_n=1; sram_waddr=0; sram_wdata=0; flush_done=0; overflow=0; flush armed flag cleared. Rows held in the FIFO are discarded.
- Push: on a rising edge with in_wen_n=0, {in_waddr, in_data} is written at the write pointer and the write pointer increments, wrapping modulo DEPTH.
- Pop: pop = sram_req & sram_gnt.
  - sram_req = (count != 0), driven combinationally from count.
  - On a pop edge, the head entry moves to the output registers, the read pointer increments, and sram_wen_n <= 0 for exactly one cycle.
  - Otherwise sram_wen_n <= 1, and sram_waddr/sram_wdata hold their last values.
- Latency, uncontended: row pushed at edge t → sram_req high in cycle t+1 → with gnt in that cycle, sram_wen_n=0 in cycle t+2. That is 2 cycles from strobe to SRAM write.
- Throughput: one push and one pop per cycle sustained. count is unchanged on simultaneous push+pop.
- Full (count==DEPTH):
  - Push with a pop in the same cycle is accepted.
  - Push with no pop is dropped: FIFO contents unchanged, overflow <= 1 (sticky).
- Empty: sram_req=0 and gnt is ignored. Pop and push in the same cycle cannot coincide on empty, because req is 0; the pushed row drains next cycle.
- Ordering: rows are written strictly in arrival order. Addresses are passed through untouched; no coalescing or bounds check.
- Flush, in_last handling:
  - in_last sets the armed flag; a row pushed in the same cycle belongs to the job.
  - While armed, flush_done pulses 1 cycle at the first edge where count==0 and sram_wen_n==1, i.e. the final write strobe has already been driven. The armed flag is then cleared.
  - If in_last arrives with the FIFO already empty and no write in flight, flush_done is asserted on the next cycle.
- start:
  - Clears overflow and the armed flag, and suppresses flush_done that cycle.
  - Does not flush the FIFO; rows from a previous job still drain.
  - start and in_last in the same cycle: start wins, and the armed flag is left cleared.
- busy = (count != 0) | (sram_wen_n == 0).

Test Plan:
- Uncontended stream: sram_gnt tied 1, 8 back-to-back rows with addresses 0..7 and data {lane i = addr+i} → 8 sram_wen_n pulses in consecutive cycles, each exactly 2 cycles after its push; addresses 0..7 in order; count never exceeds 1.
- Backpressure fill: gnt=0, push 4 rows (DEPTH=4) → count=4, sram_req=1, no write. Raise gnt → 4 writes in order over 4 cycles. overflow stays 0.
- Overflow: gnt=0, push 5 rows → 5th (addr 4) dropped, overflow=1, count=4. Then gnt=1 → only addrs 0..3 written. start → overflow=0.
- Full with simultaneous push/pop: count=4, gnt=1 and push addr 9 in the same cycle → accepted, count stays 4, overflow=0; addr 9 written last.
- Flush: 3 rows with in_last on the 3rd, gnt toggled 1,0,1,0,... → flush_done pulses once, exactly 1 cycle after the 3rd sram_wen_n pulse. in_last on an empty, idle block → flush_done on the next cycle.
- Reset mid-drain: 3 rows queued, rst_n low for 1 cycle → count=0, sram_req=0, sram_wen_n=1 immediately; no further writes after release.
